pipe_adder: RTL

Parametrised, pipelined add/subtract unit with a valid/ready handshake. It splits a WIDTH-bit add into STAGES equal carry-chained segments, one segment per clock, so wide PC/offset and address arithmetic closes timing at high clock rates. It sustains one operation per cycle. It also reports carry-out and signed overflow, and it supports backpressure and a pipeline flush for branch redirects.

---
 rtl/pipe_adder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined, segmented add/subtract unit with valid/ready handshake.
//
// A WIDTH-bit add is split into STAGES equal segments of SEG = WIDTH/STAGES bits. Each pipeline
// stage adds one segment plus the carry from the previous stage, so the critical path is one
// SEG-bit adder plus one carry flop. One operation per cycle is sustained.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   unit accepts a beat this cycle (depends only on out_valid, out_ready, flush)
//   a, b       WIDTH-bit two's complement operands
//   sub        0: a+b, 1: a-b
//   flush      drop every in-flight operation at the next edge
//   out_valid  result beat present (last stage register)
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (for subtract, 1 means no borrow)
//   ovf        signed overflow
//
// WIDTH must be a multiple of STAGES; STAGES is legal in 1..8.
module pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  // Stage registers, index s holds the output of stage s+1.
  // r_a/r_b carry the operands forward; only bits above the segments already added are consumed
  // downstream. r_s holds the partial result whose low (s+1)*SEG bits are final.
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic              r_ovf;

  logic              w_advance;
  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [WIDTH-1:0]  w_s_in  [STAGES];
  logic [WIDTH-1:0]  w_s_nxt [STAGES];
  logic [SEG:0]      w_seg   [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_c_nxt;
  logic [STAGES-1:0] w_v_in;
  logic              w_ovf_nxt;

  // The whole pipe moves in lockstep: bubbles shift too, so a stall costs every beat one cycle.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance && !flush;

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_a_in[s]  = '0;
      w_b_in[s]  = '0;
      w_s_in[s]  = '0;
      w_s_nxt[s] = '0;
      w_seg[s]   = '0;
    end
    w_c_in    = '0;
    w_c_nxt   = '0;
    w_v_in    = '0;
    w_ovf_nxt = 1'b0;

    // Stage 1 input: subtract becomes a + ~b + 1 with the +1 entering as carry-in.
    w_a_in[0] = a;
    w_b_in[0] = sub ? ~b : b;
    w_c_in[0] = sub;
    w_s_in[0] = '0;
    w_v_in[0] = in_valid && in_ready;

    for (int s = 1; s < STAGES; s++) begin
      w_a_in[s] = r_a[s-1];
      w_b_in[s] = r_b[s-1];
      w_c_in[s] = r_c[s-1];
      w_s_in[s] = r_s[s-1];
      w_v_in[s] = r_v[s-1];
    end

    for (int s = 0; s < STAGES; s++) begin
      w_seg[s] = {1'b0, w_a_in[s][s*SEG +: SEG]} + {1'b0, w_b_in[s][s*SEG +: SEG]}
               + {{SEG{1'b0}}, w_c_in[s]};
      w_s_nxt[s] = w_s_in[s];
      w_s_nxt[s][s*SEG +: SEG] = w_seg[s][SEG-1:0];
      w_c_nxt[s] = w_seg[s][SEG];
    end

    // Carry into the MSB is recovered as a^b^sum at that bit; overflow is that XOR carry out.
    w_ovf_nxt = w_a_in[STAGES-1][WIDTH-1] ^ w_b_in[STAGES-1][WIDTH-1]
              ^ w_s_nxt[STAGES-1][WIDTH-1] ^ w_c_nxt[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_a[s] <= '0;
        r_b[s] <= '0;
        r_s[s] <= '0;
      end
      r_c   <= '0;
      r_v   <= '0;
      r_ovf <= 1'b0;
    end else if (flush) begin
      // Only valids are cleared; stale data is harmless once invalid.
      r_v <= '0;
    end else if (w_advance) begin
      for (int s = 0; s < STAGES; s++) begin
        r_a[s] <= w_a_in[s];
        r_b[s] <= w_b_in[s];
        r_s[s] <= w_s_nxt[s];
      end
      r_c   <= w_c_nxt;
      r_v   <= w_v_in;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

endmodule
